// File: rtl/rf_pkg.sv
// Shared register-file types: write-port widths and the (rd, data) write request.
package rf_pkg;
  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 2 ** REG_AW;
  localparam int NUM_REQ  = 2;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } req_t;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Write-back requester handshakes plus the register-file write port and pending mask.
interface rf_wb_arbiter_if;
  logic                      req0_valid;
  logic                      req0_ready;
  logic [rf_pkg::REG_AW-1:0] req0_rd;
  logic [rf_pkg::XLEN-1:0]   req0_data;
  logic                      req1_valid;
  logic                      req1_ready;
  logic [rf_pkg::REG_AW-1:0] req1_rd;
  logic [rf_pkg::XLEN-1:0]   req1_data;
  logic                      rf_we;
  logic [rf_pkg::REG_AW-1:0] rf_waddr;
  logic [rf_pkg::XLEN-1:0]   rf_wdata;
  logic [rf_pkg::NUM_REGS-1:0] pend_mask;

  modport master (
    output req0_valid, req0_rd, req0_data, req1_valid, req1_rd, req1_data,
    input  req0_ready, req1_ready, rf_we, rf_waddr, rf_wdata, pend_mask
  );
  modport slave (
    input  req0_valid, req0_rd, req0_data, req1_valid, req1_rd, req1_data,
    output req0_ready, req1_ready, rf_we, rf_waddr, rf_wdata, pend_mask
  );
endinterface

// File: rtl/rf_wb_slot.sv
// One-entry holding slot for a write-back request; accept wins over drain.
module rf_wb_slot
  import rf_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic accept,
  input  logic drain,
  input  req_t din,
  output logic full,
  output req_t q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      full <= 1'b0;
    else if (accept) full <= 1'b1;
    else if (drain)  full <= 1'b0;
  end

  // Contents are only meaningful while full, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) q <= din;
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter of ALU/load write-back slots onto the single register-file write port.
module rf_wb_arbiter
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  rf_wb_arbiter_if.slave bus
);
  logic [NUM_REQ-1:0] vld, rdy, acc, drn, full, grant;
  req_t               din [NUM_REQ];
  req_t               q   [NUM_REQ];
  logic               rr_ptr;
  logic               gv;
  req_t               gq;
  logic [NUM_REGS-1:0] pend;

  assign vld    = {bus.req1_valid, bus.req0_valid};
  assign din[0] = '{rd: bus.req0_rd, data: bus.req0_data};
  assign din[1] = '{rd: bus.req1_rd, data: bus.req1_data};

  // Grant depends only on registered state, keeping valid->output paths out.
  always_comb begin
    grant = '0;
    case (full)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end

  assign rdy = ~full | grant;
  assign acc = vld & rdy;
  assign drn = grant & ~acc;

  for (genvar s = 0; s < NUM_REQ; s++) begin : g_slot
    rf_wb_slot u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .accept (acc[s]),
      .drain  (drn[s]),
      .din    (din[s]),
      .full   (full[s]),
      .q      (q[s])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rr_ptr <= 1'b0;
    else if (gv) rr_ptr <= grant[0];
  end

  assign gv = |grant;
  assign gq = grant[1] ? q[1] : q[0];

  always_comb begin
    pend = '0;
    for (int s = 0; s < NUM_REQ; s++)
      if (full[s] && q[s].rd != '0) pend[q[s].rd] = 1'b1;
  end

  assign bus.req0_ready = rdy[0];
  assign bus.req1_ready = rdy[1];
  assign bus.rf_we      = gv && (gq.rd != '0);
  assign bus.rf_waddr   = gv ? gq.rd   : '0;
  assign bus.rf_wdata   = gv ? gq.data : '0;
  assign bus.pend_mask  = pend;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: vector table, directed corner sequences, write scoreboard.
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rf_wb_arbiter_if bus ();
  rf_wb_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed { logic [REG_AW-1:0] a; logic [XLEN-1:0] d; } wr_t;
  typedef struct { bit port; logic [REG_AW-1:0] rd; logic [XLEN-1:0] data; bit exp_we; } vec_t;

  wr_t  sb[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(int p, bit v, logic [REG_AW-1:0] rd, logic [XLEN-1:0] d);
    if (p == 0) begin bus.req0_valid = v; bus.req0_rd = rd; bus.req0_data = d; end
    else        begin bus.req1_valid = v; bus.req1_rd = rd; bus.req1_data = d; end
  endtask

  function automatic logic [NUM_REGS-1:0] bit_of(logic [REG_AW-1:0] r);
    logic [NUM_REGS-1:0] m;
    m = '0;
    if (r != '0) m[r] = 1'b1;
    return m;
  endfunction

  // Every committed write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.rf_we === 1'b1) begin
      chk("wr_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", 64'(bus.rf_waddr), 64'(e.a));
        chk("wr_data", 64'(bus.rf_wdata), 64'(e.d));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [8];
    logic [XLEN-1:0] d0, d1;
    vt[0] = '{0, 5'd1,  32'h0000_0001, 1'b1};
    vt[1] = '{1, 5'd31, 32'hFFFF_FFFF, 1'b1};
    vt[2] = '{0, 5'd0,  32'hCAFE_0000, 1'b0};
    vt[3] = '{1, 5'd16, 32'h0000_0000, 1'b1};
    vt[4] = '{1, 5'd0,  32'h0000_5555, 1'b0};
    vt[5] = '{0, 5'd30, 32'h8000_0000, 1'b1};
    vt[6] = '{1, 5'd2,  32'h1357_9BDF, 1'b1};
    vt[7] = '{0, 5'd17, 32'h2468_ACE0, 1'b1};

    // Reset with noisy inputs
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'($urandom), 5'($urandom), $urandom);
      drive(1, 1'($urandom), 5'($urandom), $urandom);
      @(negedge clk);
      chk("rst_we",    64'(bus.rf_we), 64'd0);
      chk("rst_pend",  64'(bus.pend_mask), 64'd0);
      chk("rst_rdy0",  64'(bus.req0_ready), 64'd1);
      chk("rst_rdy1",  64'(bus.req1_ready), 64'd1);
    end
    drive(0, 0, '0, '0); drive(1, 0, '0, '0);
    rst_n = 1'b1;
    step();

    // First write after reset
    drive(0, 1, 5'd5, 32'hDEAD_BEEF);
    sb.push_back('{5'd5, 32'hDEAD_BEEF});
    @(negedge clk);
    chk("first_rdy0", 64'(bus.req0_ready), 64'd1);
    step(); drive(0, 0, '0, '0);
    @(negedge clk);
    chk("first_we",   64'(bus.rf_we), 64'd1);
    chk("first_pend", 64'(bus.pend_mask), 64'(bit_of(5'd5)));
    step();
    @(negedge clk);
    chk("first_pend_clr", 64'(bus.pend_mask), 64'd0);
    chk("first_we_clr",   64'(bus.rf_we), 64'd0);
    step();

    // Table of single uncontended requests
    for (int i = 0; i < 8; i++) begin
      drive(vt[i].port, 1, vt[i].rd, vt[i].data);
      if (vt[i].exp_we) sb.push_back('{vt[i].rd, vt[i].data});
      @(negedge clk);
      chk("vec_rdy", 64'(vt[i].port ? bus.req1_ready : bus.req0_ready), 64'd1);
      step(); drive(vt[i].port, 0, '0, '0);
      @(negedge clk);
      chk("vec_we",    64'(bus.rf_we), 64'(vt[i].exp_we));
      chk("vec_addr",  64'(bus.rf_waddr), 64'(vt[i].rd));
      chk("vec_data",  64'(bus.rf_wdata), 64'(vt[i].data));
      chk("vec_pend",  64'(bus.pend_mask), 64'(bit_of(vt[i].rd)));
      step();
      @(negedge clk);
      chk("vec_idle_pend", 64'(bus.pend_mask), 64'd0);
      step();
    end

    // Streaming on req0
    for (int i = 1; i <= 8; i++) begin
      drive(0, 1, 5'(i), 32'(i));
      sb.push_back('{5'(i), 32'(i)});
      @(negedge clk);
      chk("stream_rdy0", 64'(bus.req0_ready), 64'd1);
      step();
    end
    drive(0, 0, '0, '0);
    repeat (2) step();

    // Contention from a freshly reset pointer
    rst_n = 1'b0; #2; rst_n = 1'b1;
    step();
    d0 = 32'h100; d1 = 32'h200;
    for (int k = 0; k < 6; k++) begin
      drive(0, 1, 5'd2, d0);
      drive(1, 1, 5'd3, d1);
      @(negedge clk);
      chk("cont_rdy0", 64'(bus.req0_ready), 64'((k == 0) || (k % 2 == 1)));
      chk("cont_rdy1", 64'(bus.req1_ready), 64'((k == 0) || (k % 2 == 0)));
      if (bus.req0_ready) begin sb.push_back('{5'd2, d0}); d0++; end
      if (bus.req1_ready) begin sb.push_back('{5'd3, d1}); d1++; end
      step();
    end
    drive(0, 0, '0, '0); drive(1, 0, '0, '0);
    repeat (3) step();

    // Same rd from both units; last contention grant went to slot 0, so slot 1 is preferred
    drive(0, 1, 5'd7, 32'hA);
    drive(1, 1, 5'd7, 32'hB);
    sb.push_back('{5'd7, 32'hB});
    sb.push_back('{5'd7, 32'hA});
    @(negedge clk);
    chk("same_rdy", 64'({bus.req1_ready, bus.req0_ready}), 64'd3);
    step(); drive(0, 0, '0, '0); drive(1, 0, '0, '0);
    @(negedge clk);
    chk("same_pend0", 64'(bus.pend_mask), 64'(bit_of(5'd7)));
    step();
    @(negedge clk);
    chk("same_pend1", 64'(bus.pend_mask), 64'(bit_of(5'd7)));
    step();
    @(negedge clk);
    chk("same_pend2", 64'(bus.pend_mask), 64'd0);
    step();

    // x0 discard
    drive(1, 1, 5'd0, 32'h1234);
    @(negedge clk);
    chk("x0_rdy1", 64'(bus.req1_ready), 64'd1);
    step(); drive(1, 0, '0, '0);
    @(negedge clk);
    chk("x0_we",    64'(bus.rf_we), 64'd0);
    chk("x0_pend",  64'(bus.pend_mask), 64'd0);
    chk("x0_wdata", 64'(bus.rf_wdata), 64'h1234);
    step();
    @(negedge clk);
    chk("x0_drained_data", 64'(bus.rf_wdata), 64'd0);
    chk("x0_we2",          64'(bus.rf_we), 64'd0);
    step();

    // Reset mid-operation with both slots full
    drive(0, 1, 5'd10, 32'h10);
    drive(1, 1, 5'd11, 32'h11);
    @(posedge clk); #2;
    drive(0, 0, '0, '0); drive(1, 0, '0, '0);
    chk("mid_full_pend", 64'(bus.pend_mask), 64'(bit_of(5'd10) | bit_of(5'd11)));
    rst_n = 1'b0; #1;
    chk("mid_we",   64'(bus.rf_we), 64'd0);
    chk("mid_pend", 64'(bus.pend_mask), 64'd0);
    chk("mid_rdy",  64'({bus.req1_ready, bus.req0_ready}), 64'd3);
    #1; rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_after_we", 64'(bus.rf_we), 64'd0);
    end
    step();
    // Pointer must be back at slot 0
    drive(0, 1, 5'd12, 32'hC);
    drive(1, 1, 5'd13, 32'hD);
    sb.push_back('{5'd12, 32'hC});
    sb.push_back('{5'd13, 32'hD});
    step(); drive(0, 0, '0, '0); drive(1, 0, '0, '0);
    repeat (4) step();

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Write-back arbiter for the single write port of the 32x32 RISC-V register file.
- Two requesters, ALU write-back (req0) and load-unit write-back (req1), hand in (rd, data) over valid/ready.
- Each requester has a one-entry holding slot. Contending slots are granted round-robin.
- Outputs drive the register file write port directly (we3/ra3/wd3). The block also publishes a pending-write mask for hazard detection in issue.

Parameters:
- XLEN, 32, data width of a register write.
- REG_AW, 5, register index width; NUM_REGS = 2**REG_AW.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req0_valid  in  1  ALU write-back request valid.
- req0_ready  out  1  slot 0 can accept this cycle.
- req0_rd  in  REG_AW  destination register, ALU.
- req0_data  in  XLEN  write data, ALU.
- req1_valid  in  1  load write-back request valid.
- req1_ready  out  1  slot 1 can accept this cycle.
- req1_rd  in  REG_AW  destination register, load.
- req1_data  in  XLEN  write data, load.
- rf_we  out  1  to register file we3.
- rf_waddr  out  REG_AW  to register file ra3.
- rf_wdata  out  XLEN  to register file wd3.
- pend_mask  out  NUM_REGS  bit r=1 while any full slot holds rd=r (bit 0 always 0).

Behaviour:
- State: slotN_full, slotN_rd, slotN_data for N=0,1; rr_ptr (1 bit, preferred requester).
- Reset (async, rst_n=0): slot0_full=slot1_full=0, rr_ptr=0. Hence rf_we=0, pend_mask=0, and both ready=1 after reset release. Slot rd/data contents are don't-care.
- Grant (combinational, from registered state only):
  - Neither slot full: no grant.
  - Exactly one slot full: grant that slot.
  - Both slots full: grant slot rr_ptr.
- rr_ptr update: on any grant, rr_ptr <= index of the slot not granted. With no grant, rr_ptr holds.
- Write port:
  - rf_waddr/rf_wdata = the granted slot's rd/data.
  - rf_we = grant_valid && granted_rd != 0.
  - With no grant: rf_we=0, and rf_waddr/rf_wdata are driven 0.
- x0: a request with rd=0 is accepted, granted and drained like any other, but it never asserts rf_we.
- Ready: reqN_ready = !slotN_full || grantN. There is no combinational path from reqN_valid to any output.
- Accept: on a clock edge with reqN_valid && reqN_ready, slotN loads rd/data and slotN_full <= 1.
- Drain: on a clock edge with grantN and no accept, slotN_full <= 0.
- Simultaneous grant and accept on one slot: the old entry is written, the new entry is loaded, and the slot stays full. This gives full throughput, one write per cycle.
- Latency: request accepted at edge T, so the slot is full after T. Register file write occurs at edge T+1 if uncontended, T+2 worst case under contention.
- Fairness: with both requesters continuously valid, grants strictly alternate. No requester waits more than one grant.
- Same rd in both slots: writes commit in grant order. Program order between the units is the issue stage's job, using pend_mask.
- pend_mask:
  - Bit r is set when (slot0_full && slot0_rd==r) || (slot1_full && slot1_rd==r), for r != 0.
  - It clears on the edge that drains the last matching slot.
- Reset mid-operation: held writes are discarded and are not committed. rf_we drops asynchronously with rst_n.

Decomposition:
- Package rf_pkg holds XLEN, REG_AW, NUM_REGS, and the req_t struct {rd, data}. Both the register file and the issue-stage hazard logic share it.
- One sub-module, rf_wb_slot, is instantiated twice. It holds full/rd/data with accept/drain inputs and exposes full and contents. Arbitration, rr_ptr and pend_mask stay in the top.

Test Plan:
- Reset: hold rst_n=0 with random valid inputs. Required: rf_we=0, pend_mask=0, both ready=1. Release, send req0 rd=5 data=0xDEADBEEF. Required: rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF one cycle later; pend_mask[5]=1 for exactly that cycle.
- Streaming: req0 valid every cycle with rd=1..8 and data=i, req1 idle. Required: one write per cycle in order, req0_ready stays 1.
- Contention: both valid for 6 cycles, req0 rd=2, req1 rd=3, starting with rr_ptr=0. Required: write addresses 2,3,2,3,... and each ready=1 only on its own grant cycle.
- x0 discard: req1 rd=0 data=0x1234. Required: accepted, slot drained next cycle, rf_we=0 throughout, pend_mask=0.
- Same rd from both units: both slots full with rd=7, req0 data=0xA, req1 data=0xB, rr_ptr=1. Required: write 0xB then 0xA, pend_mask[7]=1 until the second write.
- Reset mid-operation: both slots full, then pulse rst_n low between clock edges. Required: rf_we=0 immediately, no write to the held rds after release, rr_ptr=0.
